// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, one write port and a per-register
// outstanding-write scoreboard. Define RF_BYPASS_EN for same-cycle write-through forwarding.
module rf_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic            wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  rf_q  [NREG];
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             wb_err_q, wb_err_d;

    logic             wr_hit, dec_ok, wr_unmatched, issue_acc;
    logic [NREG-1:0]  inc_vec, dec_vec;

    logic [XLEN-1:0]  rs1_store, rs2_store;
    logic             rs1_busy_store, rs2_busy_store;

    assign wr_hit       = we && (wa != '0);
    assign dec_ok       = wr_hit && (cnt_q[wa] != '0);
    assign wr_unmatched = wr_hit && (cnt_q[wa] == '0);
    assign issue_ready  = (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX);
    assign issue_acc    = issue_valid && issue_ready && (issue_rd != '0);
    assign wb_err_d     = wb_err_q || wr_unmatched;

    // Simultaneous issue and retire on the same register cancel out.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            assign inc_vec[gi] = issue_acc && (issue_rd == AW'(gi));
            assign dec_vec[gi] = dec_ok && (wa == AW'(gi));
            assign cnt_d[gi]   = (inc_vec[gi] && !dec_vec[gi]) ? cnt_q[gi] + CNT_ONE :
                                 (dec_vec[gi] && !inc_vec[gi]) ? cnt_q[gi] - CNT_ONE :
                                                                 cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            if (wr_hit) begin
                rf_q[wa] <= wd;
            end
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            wb_err_q <= wb_err_d;
        end
    end

    assign rs1_store      = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
    assign rs2_store      = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
    assign rs1_busy_store = (rs1_addr != '0) && (cnt_q[rs1_addr] != '0);
    assign rs2_busy_store = (rs2_addr != '0) && (cnt_q[rs2_addr] != '0);
    assign wb_err         = wb_err_q;

`ifdef RF_BYPASS_EN
    logic             fwd1, fwd2;
    logic [CNT_W-1:0] post_cnt;

    // Busy under forwarding reflects the count after this retire, not a same-cycle issue.
    assign post_cnt = cnt_q[wa] - CNT_W'(dec_ok);
    assign fwd1     = wr_hit && (rs1_addr == wa);
    assign fwd2     = wr_hit && (rs2_addr == wa);
    assign rs1_data = fwd1 ? wd : rs1_store;
    assign rs2_data = fwd2 ? wd : rs2_store;
    assign rs1_busy = fwd1 ? (post_cnt != '0) : rs1_busy_store;
    assign rs2_busy = fwd2 ? (post_cnt != '0) : rs2_busy_store;
`else
    assign rs1_data = rs1_store;
    assign rs2_data = rs2_store;
    assign rs1_busy = rs1_busy_store;
    assign rs2_busy = rs2_busy_store;
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed and random checks of rf_scoreboard against a behavioural array/counter model.
module tb_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int MAXC = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, issue_rd, wa;
    logic [XLEN-1:0] rs1_data, rs2_data, wd;
    logic            rs1_busy, rs2_busy, issue_valid, issue_ready, we, wb_err;

    logic [XLEN-1:0] m_rf [NREG];
    int              m_cnt [NREG];
    logic            m_err;

    int n_checks = 0;
    int n_fails  = 0;

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .we(we), .wa(wa), .wd(wd), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic fwd_hit(input logic [AW-1:0] a);
`ifdef RF_BYPASS_EN
        return we && (wa != 0) && (a == wa);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
        if (fwd_hit(a)) return wd;
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (fwd_hit(a)) return (m_cnt[a] > 1);
        return (m_cnt[a] != 0);
    endfunction

    task automatic model_update();
        logic wrv, acc;
        int   ca;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_rf[i]  = '0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            wrv = we && (wa != 0);
            ca  = m_cnt[wa];
            acc = issue_valid && (issue_rd != 0) && (m_cnt[issue_rd] < MAXC);
            if (wrv && ca == 0) m_err = 1'b1;
            if (wrv) m_rf[wa] = wd;
            if (acc) m_cnt[issue_rd]++;
            if (wrv && ca > 0) m_cnt[wa]--;
        end
    endtask

    task automatic drive(input logic r, input logic iv, input int ird, input logic w,
                         input int a, input logic [31:0] d, input int a1, input int a2);
        rst = r; issue_valid = iv; issue_rd = AW'(ird);
        we = w; wa = AW'(a); wd = d;
        rs1_addr = AW'(a1); rs2_addr = AW'(a2);
    endtask

    // Compare all outputs with the model, then clock and advance the model.
    task automatic step();
        #1;
        chk("rs1_data", rs1_data, exp_data(rs1_addr));
        chk("rs2_data", rs2_data, exp_data(rs2_addr));
        chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(rs1_addr)});
        chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(rs2_addr)});
        chk("issue_ready", {31'b0, issue_ready},
            {31'b0, (issue_rd == 0) || (m_cnt[issue_rd] != MAXC)});
        chk("wb_err", {31'b0, wb_err}, {31'b0, m_err});
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, 1'b0, 0, 32'h0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);

        // Everything reads as zero/idle after reset
        for (int a = 0; a < NREG; a++) begin
            drive(1'b0, 1'b0, a, 1'b0, 0, 32'h0, a, NREG - 1 - a);
            #1;
            chk("reset_rs1_data", rs1_data, 32'h0);
            chk("reset_rs1_busy", {31'b0, rs1_busy}, 32'h0);
            chk("reset_issue_ready", {31'b0, issue_ready}, 32'h1);
            step();
        end

        // Single issue then retire of x5
        drive(1'b0, 1'b1, 5, 1'b0, 0, 32'h0, 5, 0); step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 5, 0); #1;
        chk("x5_busy_after_issue", {31'b0, rs1_busy}, 32'h1);
        step();
        drive(1'b0, 1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 5, 0); step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 5, 0); #1;
        chk("x5_data_after_wb", rs1_data, 32'hDEADBEEF);
        chk("x5_busy_after_wb", {31'b0, rs1_busy}, 32'h0);
        step();

        // Saturate x7, hold a fourth issue, then retire and cancel
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 7, 1'b0, 0, 32'h0, 7, 7); step();
        end
        drive(1'b0, 1'b1, 7, 1'b0, 0, 32'h0, 7, 7); #1;
        chk("x7_saturated_ready", {31'b0, issue_ready}, 32'h0);
        step();
        drive(1'b0, 1'b0, 7, 1'b1, 7, 32'h00000777, 7, 7); step();
        drive(1'b0, 1'b0, 7, 1'b0, 0, 32'h0, 7, 7); #1;
        chk("x7_ready_after_retire", {31'b0, issue_ready}, 32'h1);
        step();
        drive(1'b0, 1'b1, 7, 1'b1, 7, 32'h00000778, 7, 7); step();
        drive(1'b0, 1'b1, 7, 1'b0, 0, 32'h0, 7, 7); step();
        drive(1'b0, 1'b0, 7, 1'b0, 0, 32'h0, 7, 7); #1;
        chk("x7_cancel_then_full", {31'b0, issue_ready}, 32'h0);
        step();

        // x0 ignores writes and issues
        drive(1'b0, 1'b1, 0, 1'b1, 0, 32'h12345678, 0, 0); step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 0, 0); #1;
        chk("x0_data", rs1_data, 32'h0);
        chk("x0_busy", {31'b0, rs1_busy}, 32'h0);
        chk("x0_ready", {31'b0, issue_ready}, 32'h1);
        chk("no_err_yet", {31'b0, wb_err}, 32'h0);
        step();

        // Unmatched writeback sets sticky error but still writes
        drive(1'b0, 1'b0, 0, 1'b1, 9, 32'h00000099, 9, 0); step();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 9, 0); #1;
        chk("wb_err_set", {31'b0, wb_err}, 32'h1);
        chk("x9_written", rs1_data, 32'h00000099);
        step(); step(); #1;
        chk("wb_err_sticky", {31'b0, wb_err}, 32'h1);

        // Same-cycle write and read of x3 with one pending write
        drive(1'b0, 1'b1, 3, 1'b0, 0, 32'h0, 0, 0); step();
        drive(1'b0, 1'b0, 0, 1'b1, 3, 32'hA5A5A5A5, 0, 3); #1;
`ifdef RF_BYPASS_EN
        chk("x3_fwd_data", rs2_data, 32'hA5A5A5A5);
        chk("x3_fwd_busy", {31'b0, rs2_busy}, 32'h0);
`else
        chk("x3_nofwd_data", rs2_data, 32'h0);
        chk("x3_nofwd_busy", {31'b0, rs2_busy}, 32'h1);
`endif
        step();

        // Reset wins over a coincident write
        drive(1'b0, 1'b1, 4, 1'b0, 0, 32'h0, 4, 0); step(); step();
        drive(1'b1, 1'b0, 4, 1'b1, 4, 32'hCAFEF00D, 4, 0); step();
        drive(1'b0, 1'b0, 4, 1'b0, 0, 32'h0, 4, 0); #1;
        chk("x4_after_rst_data", rs1_data, 32'h0);
        chk("x4_after_rst_busy", {31'b0, rs1_busy}, 32'h0);
        chk("wb_err_after_rst", {31'b0, wb_err}, 32'h0);
        step();

        // Random traffic over a small register window so counters saturate
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), $urandom,
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 31)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor of the core's single-cycle register file, for the pipelined CPU.
- Provides NREG x XLEN storage with two combinational read ports and one synchronous write port.
- Adds a per-register pending-write scoreboard so the decode stage can detect RAW hazards and stall.
- Sits between decode (reads, issue) and writeback (write, retire).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >= 2)
AW, $clog2(NREG), register address width (derived)
CNT_W, 2, width of per-register outstanding-write counter (max 2^CNT_W-1 in flight)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
rs1_busy  out  1  register at rs1_addr has outstanding writes
rs2_busy  out  1  register at rs2_addr has outstanding writes
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  AW  destination of issued instruction
issue_ready  out  1  counter for issue_rd not saturated (issue accepted)
we  in  1  writeback write enable (one retire = one counter decrement)
wa  in  AW  writeback address
wd  in  XLEN  writeback data
wb_err  out  1  sticky: writeback to a register with zero outstanding count

Behaviour:
- Reset (rst=1 at rising edge): all registers <= 0, all counters <= 0, wb_err <= 0. Reset wins over every simultaneous issue or write. Reset mid-operation discards in-flight state.
- Register 0: reads always return 0. rs*_busy for address 0 is always 0. Writes to address 0 are ignored. Issues to address 0 are ignored. issue_ready=1 when issue_rd=0.
- Write: on rising edge with we=1 and wa!=0, rf[wa] <= wd. Latency 1 cycle to storage.
- issue_ready = (cnt[issue_rd] != 2^CNT_W-1) || (issue_rd==0), combinational. Issue is accepted only when issue_valid && issue_ready. Decode must hold the issue while ready=0.
- Counter update per register r!=0 on each edge:
  - inc = accepted issue to r; dec = we && wa==r && cnt[r]!=0.
  - inc and dec: unchanged.
  - inc only: +1.
  - dec only: -1.
  - Never wraps: inc is blocked at max by issue_ready, dec is blocked at 0.
- wb_err: set on the edge where we=1, wa!=0 and cnt[wa]==0. In that case the write to storage still occurs. Cleared only by rst.
- rs*_busy = (addr!=0) && (cnt[addr]!=0), from registered state (see option).
- Read ports are independent; rs1_addr==rs2_addr is legal and both return the same value.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when we=1, wa!=0 and rsN_addr==wa in the same cycle:
  - rsN_data = wd (write-through forwarding).
  - rsN_busy = (cnt[wa]-dec != 0), i.e. reflects the post-retire count, ignoring a same-cycle issue.
- Undefined: reads return stored rf only, and busy uses the current cnt. The new value is visible the cycle after the write.

Test Plan:
- Reset, then read all 32 addrs -> rs1_data=rs2_data=0, all busy=0, wb_err=0, issue_ready=1.
- issue_valid, rd=5 for 1 cycle; next cycle rs1_addr=5 -> rs1_busy=1. we, wa=5, wd=0xDEADBEEF; next cycle rs1_data=0xDEADBEEF, rs1_busy=0.
- Three issues to x7 (CNT_W=2) -> issue_ready=0 for rd=7. A fourth issue held -> count stays 3. One write to x7 -> issue_ready=1. Same-cycle issue+write to x7 -> count unchanged.
- we, wa=0, wd=0x12345678; issue to x0 -> x0 reads 0, busy 0, no count change. Write to x9 with count 0 -> wb_err=1 next cycle, rf[9] updated, wb_err stays 1 until rst.
- Same-cycle write x3=0xA5A5A5A5 and read rs2_addr=3 (count 1) -> with RF_BYPASS_EN: rs2_data=0xA5A5A5A5, rs2_busy=0. Without: old value, busy=1.
- Issue x4 twice, then rst=1 coincident with we, wa=4 -> next cycle rf[4]=0, cnt[4]=0, busy=0, wb_err=0.
